div_issue_ctrl: RTL and testbench

- Execute-stage sequencer sitting directly upstream of the N-by-N integer divider in the RV32M datapath.
- Accepts DIV/DIVU/REM/REMU requests from the EX pipeline over a valid/ready handshake and drives the divider's start/operand interface under its hold rules.
- Captures quotient, remainder and error flags, and returns the selected result downstream over valid/ready.
- Holds a one-entry result cache, so a DIV followed by a REM (or the reverse) on identical operands completes without re-running the divider.

---
 rtl/div_issue_ctrl_if.sv | 45 ++++
 rtl/div_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// Request, divider and result signals of the divide issue sequencer.
// The DUT takes the slave modport; the environment takes the master modport.
interface div_issue_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             div_start;
    logic             div_is_signed;
    logic [XLEN-1:0]  div_dividend;
    logic [XLEN-1:0]  div_divisor;
    logic             div_done;
    logic [XLEN-1:0]  div_quotient;
    logic [XLEN-1:0]  div_remainder;
    logic             div_by_0;
    logic             div_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_div0;
    logic             out_ovf;

    modport slave (
        input  flush, in_valid, in_op, in_rs1, in_rs2, in_tag,
        input  div_done, div_quotient, div_remainder, div_by_0, div_ovf,
        input  out_ready,
        output in_ready, div_start, div_is_signed, div_dividend, div_divisor,
        output out_valid, out_result, out_tag, out_div0, out_ovf
    );

    modport master (
        output flush, in_valid, in_op, in_rs1, in_rs2, in_tag,
        output div_done, div_quotient, div_remainder, div_by_0, div_ovf,
        output out_ready,
        input  in_ready, div_start, div_is_signed, div_dividend, div_divisor,
        input  out_valid, out_result, out_tag, out_div0, out_ovf
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// RV32M divide issue sequencer: holds divider operands, captures results and
// keeps a one-entry quotient/remainder cache so paired DIV/REM skip the divider.
module div_issue_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TAG_W    = 5,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic            clk_in,
    input  logic            reset_in,
    div_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             div_start_q, div_start_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_div0_q, out_div0_d;
    logic             out_ovf_q, out_ovf_d;
    logic             c_valid_q, c_valid_d;
    logic [XLEN-1:0]  c_rs1_q, c_rs1_d;
    logic [XLEN-1:0]  c_rs2_q, c_rs2_d;
    logic             c_signed_q, c_signed_d;
    logic [XLEN-1:0]  c_quot_q, c_quot_d;
    logic [XLEN-1:0]  c_rem_q, c_rem_d;
    logic             c_div0_q, c_div0_d;
    logic             c_ovf_q, c_ovf_d;
    logic             cache_hit;

    // The key ignores quotient/remainder selection so DIV and REM share one entry.
    assign cache_hit = CACHE_EN && c_valid_q && (c_rs1_q == bus.in_rs1) &&
                       (c_rs2_q == bus.in_rs2) && (c_signed_q == ~bus.in_op[0]);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        tag_d        = tag_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_div0_d   = out_div0_q;
        out_ovf_d    = out_ovf_q;
        c_valid_d    = c_valid_q;
        c_rs1_d      = c_rs1_q;
        c_rs2_d      = c_rs2_q;
        c_signed_d   = c_signed_q;
        c_quot_d     = c_quot_q;
        c_rem_d      = c_rem_q;
        c_div0_d     = c_div0_q;
        c_ovf_d      = c_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    op_d  = bus.in_op;
                    rs1_d = bus.in_rs1;
                    rs2_d = bus.in_rs2;
                    tag_d = bus.in_tag;
                    if (cache_hit) begin
                        state_d      = RESP;
                        out_result_d = bus.in_op[1] ? c_rem_q : c_quot_q;
                        out_tag_d    = bus.in_tag;
                        out_div0_d   = c_div0_q;
                        out_ovf_d    = c_ovf_q;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.div_done) begin
                    if (bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = RESP;
                        out_result_d = op_q[1] ? bus.div_remainder : bus.div_quotient;
                        out_tag_d    = tag_q;
                        out_div0_d   = bus.div_by_0;
                        out_ovf_d    = bus.div_ovf;
                        if (CACHE_EN) begin
                            c_valid_d  = 1'b1;
                            c_rs1_d    = rs1_q;
                            c_rs2_d    = rs2_q;
                            c_signed_d = ~op_q[0];
                            c_quot_d   = bus.div_quotient;
                            c_rem_d    = bus.div_remainder;
                            c_div0_d   = bus.div_by_0;
                            c_ovf_d    = bus.div_ovf;
                        end
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            // The divider cannot be aborted, so a killed request runs to completion.
            DRAIN: begin
                if (bus.div_done) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (bus.out_ready || bus.flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        div_start_d = (state_d == BUSY) || (state_d == DRAIN);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            tag_q        <= '0;
            div_start_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_div0_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            c_valid_q    <= 1'b0;
            c_rs1_q      <= '0;
            c_rs2_q      <= '0;
            c_signed_q   <= 1'b0;
            c_quot_q     <= '0;
            c_rem_q      <= '0;
            c_div0_q     <= 1'b0;
            c_ovf_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            tag_q        <= tag_d;
            div_start_q  <= div_start_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_div0_q   <= out_div0_d;
            out_ovf_q    <= out_ovf_d;
            c_valid_q    <= c_valid_d;
            c_rs1_q      <= c_rs1_d;
            c_rs2_q      <= c_rs2_d;
            c_signed_q   <= c_signed_d;
            c_quot_q     <= c_quot_d;
            c_rem_q      <= c_rem_d;
            c_div0_q     <= c_div0_d;
            c_ovf_q      <= c_ovf_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.div_start     = div_start_q;
    assign bus.div_is_signed = ~op_q[0];
    assign bus.div_dividend  = rs1_q;
    assign bus.div_divisor   = rs2_q;
    assign bus.out_valid     = (state_q == RESP);
    assign bus.out_result    = out_result_q;
    assign bus.out_tag       = out_tag_q;
    assign bus.out_div0      = out_div0_q;
    assign bus.out_ovf       = out_ovf_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl with a behavioural divider of
// programmable latency attached to the divider interface.
module tb_div_issue_ctrl;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        div0;
        logic        ovf;
    } exp_t;

    logic clk_in;
    logic reset_in;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   div_lat = 2;
    int   dcnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic signed [31:0] s_a, s_d;

    div_issue_ctrl_if #(.XLEN(32), .TAG_W(5)) bus ();

    div_issue_ctrl #(.XLEN(32), .TAG_W(5), .CACHE_EN(1'b1)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;
    always @(negedge clk_in) if (bus.div_start) start_cyc <= start_cyc + 1;

    // Divider model: done after div_lat extra start cycles, garbage outside done.
    assign bus.div_done = bus.div_start && (dcnt == div_lat);
    always @(posedge clk_in) begin
        if (!bus.div_start || bus.div_done) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    always_comb begin
        s_a = bus.div_dividend;
        s_d = bus.div_divisor;
        bus.div_quotient  = 32'hDEADBEEF;
        bus.div_remainder = 32'hBADC0FFE;
        bus.div_by_0      = 1'b0;
        bus.div_ovf       = 1'b0;
        if (bus.div_done) begin
            if (bus.div_divisor == 32'd0) begin
                bus.div_quotient  = 32'hFFFFFFFF;
                bus.div_remainder = bus.div_dividend;
                bus.div_by_0      = 1'b1;
            end else if (bus.div_is_signed && bus.div_dividend == 32'h80000000 &&
                         bus.div_divisor == 32'hFFFFFFFF) begin
                bus.div_quotient  = 32'h80000000;
                bus.div_remainder = 32'd0;
                bus.div_ovf       = 1'b1;
            end else if (bus.div_is_signed) begin
                bus.div_quotient  = s_a / s_d;
                bus.div_remainder = s_a % s_d;
            end else begin
                bus.div_quotient  = bus.div_dividend / bus.div_divisor;
                bus.div_remainder = bus.div_dividend % bus.div_divisor;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_depth", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 64'(bus.out_result), 64'(mon_e.res));
                chk("tag",    64'(bus.out_tag),    64'(mon_e.tag));
                chk("div0",   64'(bus.out_div0),   64'(mon_e.div0));
                chk("ovf",    64'(bus.out_ovf),    64'(mon_e.ovf));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output int acc, output int s0);
        int n;
        @(posedge clk_in); #1;
        s0 = start_cyc;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        bus.in_tag   = tag;
        n = 0;
        @(negedge clk_in);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
        acc = cyc;
        @(posedge clk_in); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk_in);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 200) chk("out_timeout", 64'(n), 64'd0);
    endtask

    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] res,
                           input logic d0, input logic ov, input bit hit);
        int acc, s0;
        exp_q.push_back('{res: res, tag: tag, div0: d0, ovf: ov});
        send(op, a, b, tag, acc, s0);
        wait_out();
        chk("latency", 64'(cyc - acc), hit ? 64'd1 : 64'(2 + div_lat));
        chk("starts",  64'(start_cyc - s0), hit ? 64'd0 : 64'(div_lat + 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc, s0, n;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        reset_in      = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 reset_in = 1'b0;
        @(negedge clk_in);
        chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_div_start",  64'(bus.div_start),  64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_out_tag",    64'(bus.out_tag),    64'd0);
        chk("rst_out_flags",  64'({bus.out_div0, bus.out_ovf}), 64'd0);

        // DIV/REM pair and zero-divisor pair; second of each hits the cache
        div_lat = 2;
        run_req(OP_DIV,  32'd100, 32'd7, 5'd1, 32'd14, 1'b0, 1'b0, 1'b0);
        run_req(OP_REM,  32'd100, 32'd7, 5'd2, 32'd2,  1'b0, 1'b0, 1'b1);
        run_req(OP_DIVU, 32'd5,   32'd0, 5'd3, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        run_req(OP_REMU, 32'd5,   32'd0, 5'd4, 32'd5,  1'b1, 1'b0, 1'b1);
        run_req(OP_DIV,  32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        run_req(OP_REM,  32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        run_req(OP_DIVU, 32'hFFFFFFF9, 32'd2, 5'd7, 32'h7FFFFFFC, 1'b0, 1'b0, 1'b0);

        // Flush one cycle into BUSY: divider drains with operands held
        div_lat = 4;
        send(OP_DIV, 32'd1000, 32'd3, 5'd8, acc, s0);
        bus.flush = 1'b1;
        @(posedge clk_in); #1 bus.flush = 1'b0;
        n = 0;
        @(negedge clk_in);
        while (bus.div_start && n < 50) begin
            chk("drain_dividend", 64'(bus.div_dividend), 64'd1000);
            chk("drain_divisor",  64'(bus.div_divisor),  64'd3);
            chk("drain_no_out",   64'(bus.out_valid),    64'd0);
            @(negedge clk_in);
            n++;
        end
        chk("drain_starts",   64'(start_cyc - s0), 64'd5);
        chk("drain_in_ready", 64'(bus.in_ready),   64'd1);
        chk("drain_no_out",   64'(bus.out_valid),  64'd0);
        run_req(OP_REM, 32'd1000, 32'd3, 5'd9, 32'd1, 1'b0, 1'b0, 1'b0);

        // Backpressure: result held for 3 cycles, then consumed
        div_lat = 1;
        @(posedge clk_in); #1 bus.out_ready = 1'b0;
        run_req(OP_DIV, 32'd100, 32'd7, 5'd10, 32'd14, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid",    64'(bus.out_valid),  64'd1);
            chk("bp_result",   64'(bus.out_result), 64'd14);
            chk("bp_tag",      64'(bus.out_tag),    64'd10);
            chk("bp_in_ready", 64'(bus.in_ready),   64'd0);
            @(negedge clk_in);
        end
        @(posedge clk_in); #1 bus.out_ready = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("bp_idle_ready", 64'(bus.in_ready),  64'd1);
        chk("bp_idle_valid", 64'(bus.out_valid), 64'd0);

        // Signed overflow with a combinational done; identical REMs both hit
        div_lat = 0;
        run_req(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_req(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1'b0, 1'b1, 1'b1);
        run_req(OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 1'b0, 1'b1, 1'b1);

        // Accept coinciding with flush is dropped
        @(posedge clk_in); #1;
        s0 = start_cyc;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.in_op    = OP_DIV;
        bus.in_rs1   = 32'd9;
        bus.in_rs2   = 32'd3;
        bus.in_tag   = 5'd14;
        @(negedge clk_in);
        chk("fidle_ready_pre", 64'(bus.in_ready), 64'd1);
        @(posedge clk_in); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk_in);
        chk("fidle_ready", 64'(bus.in_ready),  64'd1);
        chk("fidle_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk_in);
        chk("fidle_starts", 64'(start_cyc - s0), 64'd0);

        // Flush in RESP drops the response but keeps the cache entry
        @(posedge clk_in); #1 bus.out_ready = 1'b0;
        send(OP_DIVU, 32'd9, 32'd3, 5'd15, acc, s0);
        wait_out();
        chk("fresp_result", 64'(bus.out_result), 64'd3);
        @(posedge clk_in); #1 bus.flush = 1'b1;
        @(posedge clk_in); #1 bus.flush = 1'b0;
        @(negedge clk_in);
        chk("fresp_valid", 64'(bus.out_valid), 64'd0);
        chk("fresp_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk_in); #1 bus.out_ready = 1'b1;
        run_req(OP_REMU, 32'd9, 32'd3, 5'd16, 32'd0, 1'b0, 1'b0, 1'b1);

        // Reset mid-BUSY returns to IDLE and invalidates the cache
        div_lat = 3;
        send(OP_DIV, 32'd77, 32'd5, 5'd17, acc, s0);
        reset_in = 1'b1;
        @(posedge clk_in); #1 reset_in = 1'b0;
        @(negedge clk_in);
        chk("mrst_div_start", 64'(bus.div_start), 64'd0);
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("mrst_out_tag",   64'(bus.out_tag),   64'd0);
        run_req(OP_REMU, 32'd9,  32'd3, 5'd18, 32'd0,  1'b0, 1'b0, 1'b0);
        run_req(OP_DIV,  32'd77, 32'd5, 5'd19, 32'd15, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk_in);
        chk("sb_final", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
